// File: rtl/w_bank_store.sv
// w_bank_store: kernel weight banks written from a byte stream, read through per-bank registered ports
module w_bank_store #(
    parameter int NBANK = 16,
    parameter int DEPTH = 16,
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic                clk,
    input  logic                xrst,
    input  logic                load_start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    output logic                busy,
    output logic                load_done,
    output logic                loaded,
    input  logic [NBANK*AW-1:0] w_raddr,
    output logic [NBANK*DW-1:0] w_rdata
);
    localparam int BW = $clog2(NBANK);
    localparam int CW = $clog2(NBANK * DEPTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(NBANK * DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          loaded_n;
    logic          we;
    logic [BW-1:0] wb;
    logic [AW-1:0] wa;

    assign in_ready  = state == LOAD;
    assign busy      = in_ready;
    assign load_done = state == DONE;
    assign we        = in_ready & in_valid;
    // word k lands in bank k mod NBANK, row k div NBANK
    assign wb        = cnt[BW-1:0];
    assign wa        = cnt[BW +: AW];

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state  <= IDLE;
            cnt    <= '0;
            loaded <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            loaded <= loaded_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        loaded_n = loaded;
        case (state)
            IDLE: if (load_start) begin
                state_n  = LOAD;
                cnt_n    = '0;
                loaded_n = 1'b0;
            end
            LOAD: if (we) begin
                cnt_n   = cnt + CW'(1);
                state_n = cnt == LAST ? DONE : LOAD;
            end
            DONE: begin
                state_n  = IDLE;
                loaded_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] rd;
        always_ff @(posedge clk) begin
            if (we && wb == BW'(b)) mem[wa] <= in_data;
        end
        // nonblocking read of the array gives read-first behaviour on collision
        always_ff @(posedge clk or posedge xrst) begin
            if (xrst) rd <= '0;
            else rd <= mem[w_raddr[b*AW +: AW]];
        end
        assign w_rdata[b*DW +: DW] = rd;
    end
endmodule

// File: tb/tb_w_bank_store.sv
// tb_w_bank_store: directed loads, readback, collision, abort and reset checks for w_bank_store
module tb_w_bank_store;
    localparam int NBANK = 16;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam int DW = 8;

    logic                clk = 1'b0;
    logic                xrst = 1'b1;
    logic                load_start = 1'b0;
    logic                in_valid = 1'b0;
    logic [DW-1:0]       in_data = '0;
    logic [NBANK*AW-1:0] w_raddr = '0;
    logic                in_ready, busy, load_done, loaded;
    logic [NBANK*DW-1:0] w_rdata;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    w_bank_store dut (
        .clk(clk), .xrst(xrst), .load_start(load_start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .busy(busy), .load_done(load_done),
        .loaded(loaded), .w_raddr(w_raddr), .w_rdata(w_rdata)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rd(input int b);
        return int'($signed(w_rdata[b*DW +: DW]));
    endfunction

    // base pattern: k-128; alt pattern: k as signed byte, with word 37 forced to 0x7F
    function automatic int ew(input int k, input bit alt);
        if (alt) return k == 37 ? 127 : (k < 128 ? k : k - 256);
        return k - 128;
    endfunction

    task automatic set_raddr_all(input int a);
        for (int b = 0; b < NBANK; b++) w_raddr[b*AW +: AW] = AW'(a);
    endtask

    task automatic readback(input bit alt);
        for (int a = 0; a < DEPTH; a++) begin
            set_raddr_all(a);
            @(posedge clk); #1;
            for (int b = 0; b < NBANK; b++)
                chk($sformatf("rb_a%0d_b%0d", a, b), rd(b), ew(a*NBANK + b, alt));
        end
    endtask

    task automatic do_load(input int gap, input bit alt, input int abort_at, input bit col);
        int bad = 0;
        @(posedge clk); #1 load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
        chk("busy_start", busy, 1);
        chk("loaded_clr", loaded, 0);
        for (int k = 0; k < NBANK*DEPTH; k++) begin
            in_valid = 1'b1;
            in_data = DW'(ew(k, alt));
            load_start = k == 100;
            if (!in_ready) bad++;
            if (k == abort_at) begin
                #4 xrst = 1'b1;
                #1;
                chk("abort_ready", in_ready, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", load_done, 0);
                chk("abort_loaded", loaded, 0);
                chk("abort_rdata", int'(|w_rdata), 0);
                #1 xrst = 1'b0;
                in_valid = 1'b0;
                load_start = 1'b0;
                return;
            end
            if (k == NBANK*DEPTH-1) chk("done_early", load_done, 0);
            @(posedge clk); #1;
            load_start = 1'b0;
            if (col && k == 37) chk("col_old", rd(5), -91);
            if (col && k == 38) chk("col_new", rd(5), 127);
            if (k < NBANK*DEPTH-1 && gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk); #1;
                    if (!in_ready) bad++;
                end
            end
        end
        in_valid = 1'b0;
        chk("ready_in_load", bad, 0);
        chk("load_done", load_done, 1);
        chk("busy_done", busy, 0);
        chk("ready_done", in_ready, 0);
        @(posedge clk); #1;
        chk("done_pulse", load_done, 0);
        chk("loaded", loaded, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", load_done, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_rdata", int'(|w_rdata), 0);
        xrst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        do_load(0, 1'b0, -1, 1'b0);
        readback(1'b0);
        set_raddr_all(0);
        @(posedge clk); #1;
        chk("ext_min", rd(0), -128);
        set_raddr_all(15);
        @(posedge clk); #1;
        chk("ext_max", rd(15), 127);
        set_raddr_all(3);
        @(posedge clk); #1;
        chk("a3_b0", rd(0), -80);
        chk("a3_b15", rd(15), -65);

        w_raddr[5*AW +: AW] = AW'(2);
        do_load(0, 1'b1, -1, 1'b1);
        readback(1'b1);

        do_load(2, 1'b0, -1, 1'b0);
        readback(1'b0);

        do_load(0, 1'b1, 150, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("post_abort_busy", busy, 0);
        chk("post_abort_loaded", loaded, 0);
        do_load(1, 1'b0, -1, 1'b0);
        readback(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
